// File: rtl/sm_serial_add_ctrl.sv
// Bit-serial sign-magnitude adder controller.
// One full-adder cell is reused per bit, LSB first.
module sm_serial_add_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         a_sign,
  input  logic [N-1:0] a_mag,
  input  logic         b_sign,
  input  logic [N-1:0] b_mag,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         s_sign,
  output logic [N-1:0] s_mag,
  output logic         overflow,
  output logic         busy
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] NEG  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          a_sign_q, a_sign_d;
  logic          b_sign_q, b_sign_d;
  logic [N-1:0]  a_mag_q, a_mag_d;
  logic [N-1:0]  b_mag_q, b_mag_d;
  logic          eff_sub_q, eff_sub_d;
  logic [IW-1:0] i_q, i_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          s_sign_q, s_sign_d;
  logic          ovf_q, ovf_d;

  logic fa_a, fa_b, fa_ci, fa_s, fa_co;

  // The single shared full-adder cell
  assign fa_s  = fa_a ^ fa_b ^ fa_ci;
  assign fa_co = (fa_a & fa_b) | (fa_ci & (fa_a ^ fa_b));

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign s_sign    = s_sign_q;
  assign s_mag     = sum_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d   = state_q;
    a_sign_d  = a_sign_q;
    b_sign_d  = b_sign_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    eff_sub_d = eff_sub_q;
    i_d       = i_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    s_sign_d  = s_sign_q;
    ovf_d     = ovf_q;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_ci     = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sign_d  = a_sign;
          b_sign_d  = b_sign;
          a_mag_d   = a_mag;
          b_mag_d   = b_mag;
          eff_sub_d = a_sign ^ b_sign;
          carry_d   = a_sign ^ b_sign;
          i_d       = '0;
          state_d   = ADD;
        end
      end
      ADD: begin
        fa_a       = a_mag_q[i_q];
        fa_b       = b_mag_q[i_q] ^ eff_sub_q;
        fa_ci      = carry_q;
        sum_d[i_q] = fa_s;
        carry_d    = fa_co;
        i_d        = i_q + IW'(1);
        if (i_q == LAST) begin
          if (!eff_sub_q) begin
            s_sign_d = a_sign_q & (sum_d != '0);
            ovf_d    = fa_co;
            state_d  = DONE;
          end else if (fa_co) begin
            s_sign_d = a_sign_q & (sum_d != '0);
            ovf_d    = 1'b0;
            state_d  = DONE;
          end else begin
            // |A| < |B|: the raw difference is negative, negate it
            i_d     = '0;
            carry_d = 1'b1;
            state_d = NEG;
          end
        end
      end
      NEG: begin
        fa_a       = ~sum_q[i_q];
        fa_b       = 1'b0;
        fa_ci      = carry_q;
        sum_d[i_q] = fa_s;
        carry_d    = fa_co;
        i_d        = i_q + IW'(1);
        if (i_q == LAST) begin
          s_sign_d = b_sign_q & (sum_d != '0);
          ovf_d    = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sign_q  <= 1'b0;
      b_sign_q  <= 1'b0;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      eff_sub_q <= 1'b0;
      i_q       <= '0;
      carry_q   <= 1'b0;
      sum_q     <= '0;
      s_sign_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sign_q  <= a_sign_d;
      b_sign_q  <= b_sign_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      eff_sub_q <= eff_sub_d;
      i_q       <= i_d;
      carry_q   <= carry_d;
      sum_q     <= sum_d;
      s_sign_q  <= s_sign_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sm_serial_add_ctrl.sv
// Directed bench for sm_serial_add_ctrl.
// Hand-computed vectors, N = 8.
module tb_sm_serial_add_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         a_sign;
  logic [N-1:0] a_mag;
  logic         b_sign;
  logic [N-1:0] b_mag;
  logic         out_valid;
  logic         out_ready;
  logic         s_sign;
  logic [N-1:0] s_mag;
  logic         overflow;
  logic         busy;

  int n_chk = 0;
  int n_err = 0;

  sm_serial_add_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .a_mag(a_mag),
    .b_sign(b_sign), .b_mag(b_mag),
    .out_valid(out_valid), .out_ready(out_ready),
    .s_sign(s_sign), .s_mag(s_mag),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Issue one operand pair, wait for the result, optionally hand it off
  task automatic op(input string tag,
                    input logic sa, input logic [N-1:0] ma,
                    input logic sb, input logic [N-1:0] mb,
                    input logic es, input logic [N-1:0] em,
                    input logic eo, input int elat,
                    input bit hs);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a_sign = sa; a_mag = ma;
    b_sign = sb; b_mag = mb;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(elat));
    chk({tag, ".sign"}, 32'(s_sign), 32'(es));
    chk({tag, ".mag"}, 32'(s_mag), 32'(em));
    chk({tag, ".ovf"}, 32'(overflow), 32'(eo));
    if (hs) begin
      @(posedge clk); #1;
      chk({tag, ".ov_lo"}, 32'(out_valid), 32'd0);
      chk({tag, ".rdy_hi"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_sign = 1'b0; a_mag = '0; b_sign = 1'b0; b_mag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.s_sign", 32'(s_sign), 32'd0);
    chk("rst.s_mag", 32'(s_mag), 32'd0);
    chk("rst.ovf", 32'(overflow), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    op("p5p3", 0, 8'd5, 0, 8'd3, 0, 8'd8, 0, 8, 1);
    op("p200p100", 0, 8'd200, 0, 8'd100, 0, 8'd44, 1, 8, 1);
    op("n200n100", 1, 8'd200, 1, 8'd100, 1, 8'd44, 1, 8, 1);
    op("p9n4", 0, 8'd9, 1, 8'd4, 0, 8'd5, 0, 8, 1);
    op("p4n9", 0, 8'd4, 1, 8'd9, 1, 8'd5, 0, 16, 1);
    op("n7p7", 1, 8'd7, 0, 8'd7, 0, 8'd0, 0, 8, 1);
    op("n0p0", 1, 8'd0, 0, 8'd0, 0, 8'd0, 0, 8, 1);
    op("n0n0", 1, 8'd0, 1, 8'd0, 0, 8'd0, 0, 8, 1);
    op("p128p128", 0, 8'd128, 0, 8'd128, 0, 8'd0, 1, 8, 1);
    op("n3p250", 1, 8'd3, 0, 8'd250, 0, 8'd247, 0, 16, 1);

    // Back-pressure: result held, no capture while busy
    out_ready = 1'b0;
    op("bp", 0, 8'd9, 1, 8'd4, 0, 8'd5, 0, 8, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = (k == 2);
      a_sign = 1'b0; a_mag = 8'd77;
      b_sign = 1'b0; b_mag = 8'd11;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.s_mag", 32'(s_mag), 32'd5);
      chk("bp.s_sign", 32'(s_sign), 32'd0);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.xfer", 32'(out_valid), 32'd0);
    chk("bp.rdy", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp.no_cap", 32'(busy), 32'd0);
    chk("bp.keep_mag", 32'(s_mag), 32'd5);

    // Reset in the third ADD cycle, with in_valid also high
    @(negedge clk);
    in_valid = 1'b1;
    a_sign = 1'b0; a_mag = 8'd100;
    b_sign = 1'b0; b_mag = 8'd27;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("mrst.out_valid", 32'(out_valid), 32'd0);
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.in_ready", 32'(in_ready), 32'd1);
    chk("mrst.s_mag", 32'(s_mag), 32'd0);
    op("p1p1", 0, 8'd1, 0, 8'd1, 0, 8'd2, 0, 8, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sm_serial_add_ctrl.md
Name: sm_serial_add_ctrl

Overview:
- Bit-serial sign-magnitude add controller that time-multiplexes one 1-bit full_adder instance across the operand width, LSB first.
- Accepts one sign-magnitude operand pair per valid/ready handshake and sequences add or subtract passes based on the signs.
- Performs an optional two's-complement correction pass, then returns a sign-magnitude result with overflow.
- Used as the area-minimal alternative to the ripple-carry sign-magnitude adder.

Parameters:
N, 8, magnitude width in bits (sign bit separate); N >= 2.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
a_sign  input  1  sign of A (1 = negative)
a_mag  input  N  magnitude of A
b_sign  input  1  sign of B
b_mag  input  N  magnitude of B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
s_sign  output  1  result sign
s_mag  output  N  result magnitude
overflow  output  1  magnitude overflow (same-sign add only)
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: one clk edge with rst=1 forces IDLE from any state, aborting an operation in progress.
  - Outputs after reset: out_valid=0, s_sign=0, s_mag=0, overflow=0, busy=0, in_ready=1.
- in_ready is combinational: high exactly in IDLE. There is no path from in_valid or out_ready to in_ready.
- States: IDLE, ADD, NEG, DONE.
- IDLE -> ADD on an edge with in_valid && in_ready (the accept edge).
  - Capture a_sign, a_mag, b_sign, b_mag.
  - Set the eff_sub flag to a_sign ^ b_sign.
  - Clear bit counter i to 0.
  - Load carry register with eff_sub (carry-in 1 when subtracting).
- ADD: one bit per clk. The full_adder is driven as follows:
  - Inputs: A = a_mag[i]; B = b_mag[i] ^ eff_sub; Ci = carry register.
  - S is shifted into the sum register at bit i; Co is loaded into the carry register.
  - i increments each cycle.
  - After the N-th ADD cycle (i = N-1), the final carry c is evaluated:
    - eff_sub=0: s_sign=a_sign, overflow=c, go DONE.
    - eff_sub=1 and c=1 (|A| >= |B|): s_sign=a_sign, overflow=0, go DONE.
    - eff_sub=1 and c=0 (|A| < |B|): clear i, carry register = 1, go NEG.
- NEG: two's-complement correction pass over N cycles, one bit per clk.
  - Inputs: A = ~sum[i]; B = 0; Ci = carry register. S overwrites sum[i].
  - After N cycles: s_sign=b_sign, overflow=0, go DONE.
- Zero rule: if the final magnitude is 0, s_sign is forced to 0. No negative-zero output.
- DONE: out_valid=1, and s_sign, s_mag, overflow are held stable while out_ready=0.
  - On an edge with out_valid && out_ready, go IDLE: out_valid=0 and in_ready=1 in the next cycle.
  - s_mag, s_sign and overflow retain their last values in IDLE.
- Latency (accept edge = edge 0):
  - out_valid rises after edge N (no correction) or edge 2N (with correction).
  - Minimum issue interval is N+2 cycles with out_ready held high.
- Overflow: same-sign sums wrap modulo 2^N in s_mag, with overflow=1.
- Operand inputs are ignored outside IDLE. in_valid while busy has no effect and causes no capture.
- rst asserted together with in_valid: rst wins and nothing is accepted.

Test Plan:
- N=8; +5 + +3, out_ready=1 -> out_valid 8 cycles after accept; s_sign=0, s_mag=8, overflow=0; in_ready high the cycle after the out handshake.
- +200 + +100 -> s_mag=44, s_sign=0, overflow=1; -200 + -100 -> s_mag=44, s_sign=1, overflow=1.
- +9 + -4 -> s_sign=0, s_mag=5, latency 8; +4 + -9 -> s_sign=1, s_mag=5, latency 16 (NEG pass).
- -7 + +7 -> s_sign=0, s_mag=0; -0 + +0 and -0 + -0 -> s_sign=0, s_mag=0, overflow=0.
- Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, and a new in_valid pulse is not captured; on out_ready=1, exactly one result is transferred.
- Reset mid-ADD (cycle 3 of 8) -> next cycle out_valid=0, busy=0, in_ready=1, s_mag=0; a following +1 + +1 yields s_mag=2 with normal latency.
